// File: rtl/fetch_sequencer.sv
// Purpose: chooses the PC register's next address and load strobe (increment, branch, stall hold, halt).
// Latency: pc_next/pc_load are combinational from pc_cur and inputs; state, pending branch and count update on posedge.
// Backpressure: stall holds the PC (pc_load=0) and parks any branch seen meanwhile until the stall drops.
module fetch_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_load,
  output logic              fetch_valid,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] fetch_count
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              pend_valid;
  logic              pend_valid_nxt;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] pend_target_nxt;
  logic              fault_nxt;
  logic              br_in_range;
  logic              pend_in_range;

  assign br_in_range   = (branch_target < DEPTH_A);
  assign pend_in_range = (pend_target < DEPTH_A);

  // Next-state and PC source selection; earlier branches of the if-chain take priority.
  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    fault_nxt       = fault;
    pc_next         = pc_cur;
    pc_load         = 1'b0;
    fetch_valid     = 1'b0;
    halted          = 1'b0;
    case (state)
      BOOT: begin
        // One settling cycle after reset; a branch arriving here is dropped.
        state_nxt = RUN;
      end
      RUN: begin
        fetch_valid = !halt_req && (pc_cur < DEPTH_A);
        if (halt_req) begin
          state_nxt = HALT;
        end else if (stall) begin
          // Hold the PC; the newest branch seen during the stall wins.
          if (branch_taken) begin
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = branch_target;
          end
        end else if (branch_taken && !br_in_range) begin
          fault_nxt = 1'b1;
          state_nxt = HALT;
        end else if (branch_taken) begin
          pc_next        = branch_target;
          pc_load        = 1'b1;
          pend_valid_nxt = 1'b0;
        end else if (pend_valid && !pend_in_range) begin
          fault_nxt      = 1'b1;
          pend_valid_nxt = 1'b0;
          state_nxt      = HALT;
        end else if (pend_valid) begin
          pc_next        = pend_target;
          pc_load        = 1'b1;
          pend_valid_nxt = 1'b0;
        end else if (pc_cur >= LAST_A) begin
          // End of instruction memory (or a PC already past it): stop, never wrap.
          state_nxt = HALT;
        end else begin
          pc_next = pc_cur + ONE_A;
          pc_load = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // State, pending-branch and sticky-fault registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      fault       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      fault       <= fault_nxt;
    end
  end

  // Count PC advances in RUN, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if ((state == RUN) && pc_load && (fetch_count != '1)) begin
      fetch_count <= fetch_count + ONE_A;
    end
  end

  // Any address handed to the PC register must lie inside instruction memory.
  load_in_range: assert property (@(posedge clk) disable iff (!rst) pc_load |-> (pc_next < DEPTH_A));

endmodule
